// File: rtl/chart_sequencer_if.sv
// Chart ROM read port plus the note-spawn valid/ready handshake.
// The master modport is the sequencer side; the slave modport is the ROM / vga_controller side.
interface chart_sequencer_if #(
  parameter int ADDR_W = 8
);
  logic [ADDR_W-1:0] chart_addr;
  logic [7:0]        chart_data;
  logic              spawn_valid;
  logic [3:0]        spawn_lanes;
  logic              spawn_ready;

  modport master (
    output chart_addr, spawn_valid, spawn_lanes,
    input  chart_data, spawn_ready
  );

  modport slave (
    input  chart_addr, spawn_valid, spawn_lanes,
    output chart_data, spawn_ready
  );
endinterface

// File: rtl/chart_sequencer.sv
// Walks a note chart in synchronous ROM, one entry per g+1 beat steps,
// and issues lane-spawn requests with overrun and end-of-chart reporting.
module chart_sequencer #(
  parameter int TICKS_PER_STEP = 12_500_000,
  parameter int ADDR_W         = 8
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              start_i,
  input  logic              pause_i,
  chart_sequencer_if.master bus,
  output logic              busy_o,
  output logic              done_o,
  output logic              overrun_o,
  output logic [15:0]       step_count_o
);
  localparam int                TICK_W    = (TICKS_PER_STEP > 1) ? $clog2(TICKS_PER_STEP) : 1;
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICKS_PER_STEP - 1);
  localparam logic [ADDR_W-1:0] ADDR_LAST = {ADDR_W{1'b1}};

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_FETCH    = 3'd1,
    S_LATCH    = 3'd2,
    S_ISSUE    = 3'd3,
    S_WAIT_GAP = 3'd4,
    S_DONE     = 3'd5
  } state_e;

  state_e            state_q, state_d;
  logic [TICK_W-1:0] tick_q, tick_d;
  logic [3:0]        gap_q, gap_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              valid_q, valid_d;
  logic [3:0]        lanes_q, lanes_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              overrun_q, overrun_d;
  logic [15:0]       steps_q, steps_d;

  logic step_pulse;
  logic handshake;
  logic start_accept;
  logic advance;

  assign step_pulse   = busy_q & ~pause_i & (tick_q == TICK_LAST);
  assign handshake    = valid_q & bus.spawn_ready;
  assign start_accept = start_i & ((state_q == S_IDLE) | (state_q == S_DONE));

  // Next-state, beat timer and output-register updates.
  always_comb begin
    state_d   = state_q;
    tick_d    = tick_q;
    gap_d     = gap_q;
    addr_d    = addr_q;
    valid_d   = valid_q;
    lanes_d   = lanes_q;
    done_d    = done_q;
    overrun_d = overrun_q;
    steps_d   = steps_q;
    advance   = 1'b0;

    if (start_accept) begin
      tick_d  = {TICK_W{1'b0}};
      steps_d = 16'd0;
    end else if (busy_q && !pause_i) begin
      tick_d = (tick_q == TICK_LAST) ? {TICK_W{1'b0}} : tick_q + TICK_W'(1);
      if (step_pulse && (steps_q != 16'hFFFF)) begin
        steps_d = steps_q + 16'd1;
      end else begin
        steps_d = steps_q;
      end
    end else begin
      tick_d = tick_q;
    end

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start_i) begin
          state_d   = S_FETCH;
          addr_d    = {ADDR_W{1'b0}};
          done_d    = 1'b0;
          overrun_d = 1'b0;
        end else begin
          state_d = state_q;
        end
      end
      S_FETCH: state_d = S_LATCH;
      S_LATCH: begin
        if (bus.chart_data[7]) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end else begin
          gap_d = {1'b0, bus.chart_data[6:4]} + 4'd1 - {3'b000, step_pulse};
          if (bus.chart_data[3:0] != 4'd0) begin
            state_d = S_ISSUE;
            valid_d = 1'b1;
            lanes_d = bus.chart_data[3:0];
          end else begin
            state_d = S_WAIT_GAP;
          end
        end
      end
      S_ISSUE: begin
        if (step_pulse) begin
          gap_d = gap_q - 4'd1;
        end else begin
          gap_d = gap_q;
        end
        // A transfer on the entry's final step still counts; only a missed one is an overrun.
        if (step_pulse && (gap_q == 4'd1)) begin
          valid_d = 1'b0;
          advance = 1'b1;
          if (!handshake) begin
            overrun_d = 1'b1;
          end else begin
            overrun_d = overrun_q;
          end
        end else if (handshake) begin
          valid_d = 1'b0;
          state_d = S_WAIT_GAP;
        end else begin
          state_d = S_ISSUE;
        end
      end
      S_WAIT_GAP: begin
        if (step_pulse) begin
          gap_d   = gap_q - 4'd1;
          advance = (gap_q == 4'd1);
        end else begin
          gap_d = gap_q;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (advance) begin
      if (addr_q == ADDR_LAST) begin
        state_d = S_DONE;
        done_d  = 1'b1;
      end else begin
        addr_d  = addr_q + ADDR_W'(1);
        state_d = S_FETCH;
      end
    end else begin
      addr_d = addr_d;
    end

    busy_d = (state_d != S_IDLE) && (state_d != S_DONE);
  end

  // State and output registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= S_IDLE;
      tick_q    <= {TICK_W{1'b0}};
      gap_q     <= 4'd0;
      addr_q    <= {ADDR_W{1'b0}};
      valid_q   <= 1'b0;
      lanes_q   <= 4'd0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      overrun_q <= 1'b0;
      steps_q   <= 16'd0;
    end else begin
      state_q   <= state_d;
      tick_q    <= tick_d;
      gap_q     <= gap_d;
      addr_q    <= addr_d;
      valid_q   <= valid_d;
      lanes_q   <= lanes_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      overrun_q <= overrun_d;
      steps_q   <= steps_d;
    end
  end

  assign bus.chart_addr  = addr_q;
  assign bus.spawn_valid = valid_q;
  assign bus.spawn_lanes = lanes_q;
  assign busy_o          = busy_q;
  assign done_o          = done_q;
  assign overrun_o       = overrun_q;
  assign step_count_o    = steps_q;
endmodule

// File: tb/tb_chart_sequencer.sv
// Scoreboard bench for chart_sequencer: expected spawns (lanes, cycle) are queued
// when a chart is loaded and popped on every observed handshake.
module tb_chart_sequencer;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, start_a, pause_a, start_b;
  logic        busy_a, done_a, ovr_a, busy_b, done_b, ovr_b;
  logic [15:0] steps_a, steps_b;

  chart_sequencer_if #(.ADDR_W(8)) bus_a ();
  chart_sequencer_if #(.ADDR_W(2)) bus_b ();

  chart_sequencer #(.TICKS_PER_STEP(8), .ADDR_W(8)) dut_a (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start_a), .pause_i(pause_a), .bus(bus_a),
    .busy_o(busy_a), .done_o(done_a), .overrun_o(ovr_a), .step_count_o(steps_a)
  );

  chart_sequencer #(.TICKS_PER_STEP(4), .ADDR_W(2)) dut_b (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start_b), .pause_i(1'b0), .bus(bus_b),
    .busy_o(busy_b), .done_o(done_b), .overrun_o(ovr_b), .step_count_o(steps_b)
  );

  logic [7:0] rom_a [256];
  logic [7:0] rom_b [4];
  always @(posedge clk) bus_a.chart_data <= rom_a[bus_a.chart_addr];
  always @(posedge clk) bus_b.chart_data <= rom_b[bus_b.chart_addr];

  typedef struct {
    logic [3:0] lanes;
    int         at;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   start_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc - start_cyc);
    end
  endtask

  // Every accepted spawn must match the head of the scoreboard in lanes and cycle.
  always @(negedge clk) begin
    if (rst_n && bus_a.spawn_valid && bus_a.spawn_ready) begin
      check_eq("sb_has_entry", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        mon_e = sb.pop_front();
        check_eq("spawn_lanes", 32'(bus_a.spawn_lanes), 32'(mon_e.lanes));
        check_eq("spawn_cycle", cyc - start_cyc, mon_e.at);
      end
    end
  end

  task automatic load_a(input logic [7:0] e0, input logic [7:0] e1, input logic [7:0] e2);
    for (int i = 0; i < 256; i++) rom_a[i] = 8'h80;
    rom_a[0] = e0;
    rom_a[1] = e1;
    rom_a[2] = e2;
  endtask

  task automatic goto(input int n);
    while (cyc < start_cyc + n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic start_run(input int hold);
    @(posedge clk);
    #1;
    start_a   = 1'b1;
    start_cyc = cyc;
    goto(hold);
    start_a = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int exp_at, input bit no_valid);
    int  n = 0;
    bit  saw_valid = 1'b0;
    while (!done_a && n < 300) begin
      @(negedge clk);
      n++;
      if (bus_a.spawn_valid) saw_valid = 1'b1;
    end
    check_eq({tag, "_done_cyc"}, done_a ? cyc - start_cyc : -1, exp_at);
    if (no_valid) check_eq({tag, "_no_valid"}, 32'(saw_valid), 32'd0);
    check_eq({tag, "_sb_drained"}, sb.size(), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    rst_n = 1'b0; start_a = 1'b0; pause_a = 1'b0; start_b = 1'b0;
    bus_a.spawn_ready = 1'b1;
    bus_b.spawn_ready = 1'b1;
    load_a(8'h80, 8'h80, 8'h80);
    rom_b[0] = 8'h00; rom_b[1] = 8'h10; rom_b[2] = 8'h00; rom_b[3] = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_busy", 32'(busy_a), 32'd0);
    check_eq("rst_done", 32'(done_a), 32'd0);
    check_eq("rst_ovr", 32'(ovr_a), 32'd0);
    check_eq("rst_valid", 32'(bus_a.spawn_valid), 32'd0);
    check_eq("rst_addr", 32'(bus_a.chart_addr), 32'd0);
    check_eq("rst_steps", 32'(steps_a), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // T5b: 4-entry chart without an end bit on a 2-bit address space
    @(posedge clk);
    #1;
    start_b   = 1'b1;
    start_cyc = cyc;
    @(posedge clk);
    #1;
    start_b = 1'b0;
    n = 0;
    while (!done_b && n < 100) begin
      @(negedge clk);
      n++;
      check_eq("t5b_no_valid", 32'(bus_b.spawn_valid), 32'd0);
    end
    check_eq("t5b_done_cyc", done_b ? cyc - start_cyc : -1, 21);
    check_eq("t5b_addr", 32'(bus_b.chart_addr), 32'd3);
    check_eq("t5b_steps", 32'(steps_b), 32'd5);
    repeat (3) @(negedge clk);
    check_eq("t5b_addr_hold", 32'(bus_b.chart_addr), 32'd3);

    // T1: basic chart, start held high while busy
    load_a(8'h01, 8'h12, 8'h80);
    bus_a.spawn_ready = 1'b1;
    sb.push_back('{4'b0001, 3});
    sb.push_back('{4'b0010, 11});
    start_run(4);
    @(negedge clk);
    check_eq("t1_busy", 32'(busy_a), 32'd1);
    wait_done("t1", 27, 1'b0);
    check_eq("t1_steps", 32'(steps_a), 32'd3);
    check_eq("t1_ovr", 32'(ovr_a), 32'd0);
    check_eq("t1_busy_end", 32'(busy_a), 32'd0);

    // T2: backpressure for three cycles
    load_a(8'h01, 8'h80, 8'h80);
    bus_a.spawn_ready = 1'b0;
    sb.push_back('{4'b0001, 6});
    start_run(1);
    for (int c = 3; c <= 5; c++) begin
      goto(c);
      @(negedge clk);
      check_eq("t2_valid_hold", 32'(bus_a.spawn_valid), 32'd1);
      check_eq("t2_lanes_hold", 32'(bus_a.spawn_lanes), 32'd1);
    end
    goto(6);
    bus_a.spawn_ready = 1'b1;
    @(negedge clk);
    goto(7);
    @(negedge clk);
    check_eq("t2_valid_drop", 32'(bus_a.spawn_valid), 32'd0);
    wait_done("t2", 11, 1'b0);
    check_eq("t2_ovr", 32'(ovr_a), 32'd0);

    // T3: no ready at all, entry dropped at its only step
    load_a(8'h01, 8'h80, 8'h80);
    bus_a.spawn_ready = 1'b0;
    start_run(1);
    goto(8);
    @(negedge clk);
    check_eq("t3_valid_c8", 32'(bus_a.spawn_valid), 32'd1);
    check_eq("t3_ovr_c8", 32'(ovr_a), 32'd0);
    goto(9);
    @(negedge clk);
    check_eq("t3_valid_c9", 32'(bus_a.spawn_valid), 32'd0);
    check_eq("t3_ovr_c9", 32'(ovr_a), 32'd1);
    check_eq("t3_addr_c9", 32'(bus_a.chart_addr), 32'd1);
    wait_done("t3", 11, 1'b0);
    check_eq("t3_ovr_sticky", 32'(ovr_a), 32'd1);

    // T4: pause for 20 cycles while waiting out the gap
    load_a(8'h01, 8'h12, 8'h80);
    bus_a.spawn_ready = 1'b1;
    sb.push_back('{4'b0001, 3});
    sb.push_back('{4'b0010, 31});
    start_run(1);
    @(negedge clk);
    check_eq("t4_ovr_cleared", 32'(ovr_a), 32'd0);
    goto(4);
    pause_a = 1'b1;
    goto(20);
    @(negedge clk);
    check_eq("t4_steps_frozen", 32'(steps_a), 32'd0);
    goto(24);
    pause_a = 1'b0;
    goto(29);
    @(negedge clk);
    check_eq("t4_steps_resume", 32'(steps_a), 32'd1);
    wait_done("t4", 47, 1'b0);
    check_eq("t4_steps", 32'(steps_a), 32'd3);

    // T5: empty-lane entry with g=2
    load_a(8'h20, 8'h80, 8'h80);
    start_run(1);
    wait_done("t5", 27, 1'b1);
    check_eq("t5_steps", 32'(steps_a), 32'd3);

    // T7: handshake lands on the entry's final step pulse
    load_a(8'h01, 8'h80, 8'h80);
    bus_a.spawn_ready = 1'b0;
    sb.push_back('{4'b0001, 8});
    start_run(1);
    goto(8);
    bus_a.spawn_ready = 1'b1;
    wait_done("t7", 11, 1'b0);
    check_eq("t7_ovr", 32'(ovr_a), 32'd0);

    // T6: reset asserted while the second entry is being offered
    load_a(8'h01, 8'h01, 8'h80);
    bus_a.spawn_ready = 1'b0;
    start_run(1);
    goto(11);
    @(negedge clk);
    check_eq("t6_pre_valid", 32'(bus_a.spawn_valid), 32'd1);
    check_eq("t6_pre_ovr", 32'(ovr_a), 32'd1);
    goto(12);
    rst_n = 1'b0;
    #1;
    check_eq("t6_rst_valid", 32'(bus_a.spawn_valid), 32'd0);
    check_eq("t6_rst_ovr", 32'(ovr_a), 32'd0);
    check_eq("t6_rst_busy", 32'(busy_a), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    load_a(8'h02, 8'h80, 8'h80);
    bus_a.spawn_ready = 1'b1;
    sb.push_back('{4'b0010, 3});
    start_run(1);
    @(negedge clk);
    check_eq("t6_restart_addr", 32'(bus_a.chart_addr), 32'd0);
    wait_done("t6", 11, 1'b0);

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
